// File: rtl/seg_scan4_if.sv
// Display-scanner bus: the value/load/decimal-point inputs and the digit drive outputs.
// The master is the producer of display data; the slave is the scanner.
interface seg_scan4_if;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  pos;
    logic [7:0]  seg;
    logic        upd_ack;
    logic        frame_done;

    modport master (
        output din, dp_in, load, lz_blank,
        input  pos, seg, upd_ack, frame_done
    );

    modport slave (
        input  din, dp_in, load, lz_blank,
        output pos, seg, upd_ack, frame_done
    );
endinterface

// File: rtl/seg_scan4.sv
// Purpose: time-multiplexed 4-digit 7-segment driver with per-slot blanking and frame-aligned updates.
// Latency: pos/seg one cycle behind the scan counters; a load shows up in the frame after the next boundary.
// Backpressure: none; load is always accepted, the last load before a boundary wins.
module seg_scan4 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan4_if.slave  bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [15:0]   pend_q, pend_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    pos_q, pos_d;
    logic [7:0]    seg_q, seg_d;
    logic          upd_ack_q, upd_ack_d;
    logic          frame_done_q, frame_done_d;

    logic          last_cyc;
    logic          boundary;
    logic [3:0]    digit;
    logic          supp;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h08;  // non-decimal value: lone bottom bar flags an error
        endcase
        return s;
    endfunction

    always_comb begin
        last_cyc = (cnt_q == CNT_LAST);
        boundary = last_cyc && (idx_q == 2'd3);

        cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
        idx_d = last_cyc ? idx_q + 2'd1 : idx_q;

        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;

        if (boundary) begin
            pend_v_d = 1'b0;
            if (bus.load) begin
                disp_d    = bus.din;
                disp_dp_d = bus.dp_in;
            end else if (pend_v_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
        end else if (bus.load) begin
            pend_d    = bus.din;
            pend_dp_d = bus.dp_in;
            pend_v_d  = 1'b1;
        end

        upd_ack_d    = boundary && (bus.load || pend_v_q);
        frame_done_d = boundary;

        case (idx_q)
            2'd0:    digit = disp_q[3:0];
            2'd1:    digit = disp_q[7:4];
            2'd2:    digit = disp_q[11:8];
            default: digit = disp_q[15:12];
        endcase

        // A digit is a leading zero only if it and every digit to its left are zero.
        case (idx_q)
            2'd1:    supp = (disp_q[15:4] == 12'h000);
            2'd2:    supp = (disp_q[15:8] == 8'h00);
            2'd3:    supp = (disp_q[15:12] == 4'h0);
            default: supp = 1'b0;
        endcase
        supp = supp && bus.lz_blank;

        if (cnt_q < BLANK_LIM) begin
            pos_d = 4'b0000;
            seg_d = 8'h00;
        end else begin
            pos_d = 4'b0001 << idx_q;
            seg_d = {disp_dp_q[idx_q], supp ? 7'h00 : seg7(digit)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            disp_dp_q    <= 4'h0;
            pend_q       <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_v_q     <= 1'b0;
            pos_q        <= 4'h0;
            seg_q        <= 8'h00;
            upd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            pos_q        <= pos_d;
            seg_q        <= seg_d;
            upd_ack_q    <= upd_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pos        = pos_q;
    assign bus.seg        = seg_q;
    assign bus.upd_ack    = upd_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with SCAN_DIV=8, BLANK_CYC=2: one 32-cycle frame per play_frame call,
// each test compares every cycle of a frame against hand-written per-slot segment tables.
module tb_seg_scan4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan4_if bus();

    seg_scan4 #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] obs_pos [32];
    logic [7:0] obs_seg [32];
    logic       obs_fd  [32];
    logic       obs_ack [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays one frame (must start frame-aligned), pulsing load at cycle la and/or lb (-1 = none).
    task automatic play_frame(input int la, input logic [15:0] da, input logic [3:0] pa,
                              input int lb, input logic [15:0] db, input logic [3:0] pb);
        for (int i = 0; i < 32; i++) begin
            bus.load = (i == la) || (i == lb);
            if (i == la) begin bus.din = da; bus.dp_in = pa; end
            if (i == lb) begin bus.din = db; bus.dp_in = pb; end
            tick();
            obs_pos[i] = bus.pos;
            obs_seg[i] = bus.seg;
            obs_fd[i]  = bus.frame_done;
            obs_ack[i] = bus.upd_ack;
        end
        bus.load = 1'b0;
    endtask

    // Expected {pos, seg, frame_done, upd_ack} for frame cycle i; segs = {slot3, slot2, slot1, slot0}.
    function automatic logic [13:0] want_vec(input int i, input logic [31:0] segs, input logic ack);
        int         slot;
        logic       lit;
        logic [3:0] p;
        logic [7:0] s;
        slot = i / 8;
        lit  = (i % 8) >= 2;
        p    = lit ? (4'b0001 << slot) : 4'b0000;
        s    = lit ? segs[slot*8 +: 8] : 8'h00;
        return {p, s, (i == 31), (i == 31) && ack};
    endfunction

    task automatic test_reset();
        bus.din = 16'h0000; bus.dp_in = 4'h0; bus.load = 1'b0; bus.lz_blank = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (bus.pos !== 4'h0) begin tests_failed++; $display("FAIL reset_pos got %h expected 0", bus.pos); end
        tests_run++;
        if (bus.seg !== 8'h00) begin tests_failed++; $display("FAIL reset_seg got %h expected 00", bus.seg); end
        tests_run++;
        if (bus.upd_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got %b expected 0", bus.upd_ack); end
        tests_run++;
        if (bus.frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_fd got %b expected 0", bus.frame_done); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_startup();
        for (int f = 0; f < 2; f++) begin
            play_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, 32'h3F3F3F3F, 1'b0)) begin
                    tests_failed++;
                    $display("FAIL startup f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, 32'h3F3F3F3F, 1'b0));
                end
            end
        end
    endtask

    task automatic test_deferred();
        logic [31:0] segs [2];
        logic        acks [2];
        segs = '{32'h3F3F3F3F, 32'h065B4F66};
        acks = '{1'b1, 1'b0};
        for (int f = 0; f < 2; f++) begin
            play_frame((f == 0) ? 9 : -1, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, segs[f], acks[f])) begin
                    tests_failed++;
                    $display("FAIL deferred f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, segs[f], acks[f]));
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [3];
        logic [31:0] segs [3];
        logic        acks [3];
        vals = '{16'h0050, 16'h0000, 16'h0000};
        segs = '{32'h065B4F66, 32'h00006D3F, 32'h0000003F};
        acks = '{1'b1, 1'b1, 1'b0};
        bus.lz_blank = 1'b1;
        for (int f = 0; f < 3; f++) begin
            play_frame((f < 2) ? 5 : -1, vals[f], 4'h0, -1, 16'h0, 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, segs[f], acks[f])) begin
                    tests_failed++;
                    $display("FAIL leading_zero f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, segs[f], acks[f]));
                end
            end
        end
    endtask

    task automatic test_error_dp();
        logic [31:0] segs [2];
        logic        acks [2];
        segs = '{32'h3F3F3F3F, 32'h3F3F883F};
        acks = '{1'b1, 1'b0};
        bus.lz_blank = 1'b0;
        for (int f = 0; f < 2; f++) begin
            play_frame((f == 0) ? 5 : -1, 16'h00A0, 4'b0010, -1, 16'h0, 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, segs[f], acks[f])) begin
                    tests_failed++;
                    $display("FAIL error_dp f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, segs[f], acks[f]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          la [3], lb [3];
        logic [15:0] da [3], db [3];
        logic [31:0] segs [3];
        logic        acks [3];
        // Frame 0: two loads, last wins. Frame 1: pending 4444 overridden by a load on the boundary.
        la = '{3, 5, -1};                  lb = '{20, 31, -1};
        da = '{16'h1111, 16'h4444, 16'h0}; db = '{16'h2222, 16'h3333, 16'h0};
        segs = '{32'h3F3F883F, 32'h5B5B5B5B, 32'h4F4F4F4F};
        acks = '{1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 3; f++) begin
            play_frame(la[f], da[f], 4'h0, lb[f], db[f], 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, segs[f], acks[f])) begin
                    tests_failed++;
                    $display("FAIL back_to_back f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, segs[f], acks[f]));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 20; i++) begin
            bus.load = (i == 5);
            bus.din  = 16'h5555;
            bus.dp_in = 4'hF;
            tick();
        end
        bus.load = 1'b0;
        tests_run++;
        if (bus.pos !== 4'b0100 || bus.seg !== 8'h4F) begin
            tests_failed++;
            $display("FAIL async_pre pos/seg got %h/%h expected 4/4f", bus.pos, bus.seg);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.pos !== 4'h0 || bus.seg !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_now pos/seg got %h/%h expected 0/00", bus.pos, bus.seg);
        end
        repeat (2) tick();
        #2 rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            play_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
            for (int i = 0; i < 32; i++) begin
                tests_run++;
                if ({obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]} !== want_vec(i, 32'h3F3F3F3F, 1'b0)) begin
                    tests_failed++;
                    $display("FAIL async_after f%0d i=%0d pos/seg/fd/ack got %h expected %h", f, i,
                             {obs_pos[i], obs_seg[i], obs_fd[i], obs_ack[i]}, want_vec(i, 32'h3F3F3F3F, 1'b0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_deferred();
        test_leading_zero();
        test_error_dp();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1);
    end

endmodule
